// File: rtl/cl_axi_slv_pkg.sv
// Shared types and constants for the on-chip AXI responder memory.
package cl_axi_slv_pkg;

    localparam int ID_W       = 16;
    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 512;
    localparam int STRB_W     = DATA_W / 8;
    localparam int LINE_BYTES = 64;
    localparam int LINE_OFS   = $clog2(LINE_BYTES);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_FETCH,
        RD_DATA
    } state_t;

endpackage

// File: rtl/axi_bus_t.sv
// 512-bit data / 64-bit address AXI4 bundle; the master modport is the responder's view.
interface axi_bus_t;
    import cl_axi_slv_pkg::*;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/cl_axi_slv_ram.sv
// Single-port line memory with per-byte write enables and a registered read port.
module cl_axi_slv_ram
    import cl_axi_slv_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [STRB_W-1:0]        we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-before-write: rdata shows the old line during a write, which nobody consumes.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (we[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/cl_axi_slv_mem.sv
// AXI4 responder backed by a byte-enabled line RAM; one burst in flight, INCR only.
module cl_axi_slv_mem
    import cl_axi_slv_pkg::*;
#(
    parameter  int DEPTH = 1024,
    localparam int LAW   = $clog2(DEPTH)
) (
    input  logic        aclk,
    input  logic        aresetn,
    axi_bus_t.master    cl_axi_slv_bus,
    output logic        busy,
    output logic [15:0] err_cnt
);

    state_t            state, next_state;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        cnt_q;
    logic [2:0]        size_q;
    logic              err_q;
    logic              rd_prio;
    logic              idle, aw_hs, ar_hs, w_hs, b_hs, r_hs;
    logic              last_beat, beat_oor, ram_en;
    logic [ADDR_W-1:0] beat_step;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_burst;

    assign unused_burst = ^{cl_axi_slv_bus.awburst, cl_axi_slv_bus.arburst};

    assign idle      = (state == IDLE) && aresetn;
    assign last_beat = (cnt_q == 8'd0);
    assign beat_oor  = |addr_q[ADDR_W-1:LINE_OFS+LAW];
    assign beat_step = ADDR_W'(1) << size_q;

    // Only the favoured direction sees ready when both requests are pending.
    assign cl_axi_slv_bus.awready = idle && !(cl_axi_slv_bus.arvalid && rd_prio);
    assign cl_axi_slv_bus.arready = idle && !(cl_axi_slv_bus.awvalid && !rd_prio);

    assign aw_hs = cl_axi_slv_bus.awvalid && cl_axi_slv_bus.awready;
    assign ar_hs = cl_axi_slv_bus.arvalid && cl_axi_slv_bus.arready;
    assign w_hs  = (state == WR_DATA) && cl_axi_slv_bus.wvalid;
    assign b_hs  = (state == WR_RESP) && cl_axi_slv_bus.bready;
    assign r_hs  = (state == RD_DATA) && cl_axi_slv_bus.rready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (aw_hs) begin
                    next_state = WR_DATA;
                end else if (ar_hs) begin
                    next_state = RD_FETCH;
                end
            end
            WR_DATA:  if (w_hs && last_beat) next_state = WR_RESP;
            WR_RESP:  if (b_hs) next_state = IDLE;
            RD_FETCH: next_state = RD_DATA;
            RD_DATA:  if (r_hs) next_state = last_beat ? IDLE : RD_FETCH;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            id_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            err_q   <= 1'b0;
            rd_prio <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (aw_hs) begin
                id_q    <= cl_axi_slv_bus.awid;
                addr_q  <= cl_axi_slv_bus.awaddr;
                cnt_q   <= cl_axi_slv_bus.awlen;
                size_q  <= cl_axi_slv_bus.awsize;
                err_q   <= 1'b0;
                rd_prio <= 1'b1;
            end else if (ar_hs) begin
                id_q    <= cl_axi_slv_bus.arid;
                addr_q  <= cl_axi_slv_bus.araddr;
                cnt_q   <= cl_axi_slv_bus.arlen;
                size_q  <= cl_axi_slv_bus.arsize;
                err_q   <= 1'b0;
                rd_prio <= 1'b0;
            end
            if (w_hs) begin
                if (beat_oor || (cl_axi_slv_bus.wlast != last_beat)) begin
                    err_q <= 1'b1;
                end
                if (!last_beat) begin
                    cnt_q  <= cnt_q - 8'd1;
                    addr_q <= addr_q + beat_step;
                end
            end
            if (b_hs) begin
                err_q <= 1'b0;
                if (err_q && (err_cnt != 16'hFFFF)) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end
            // The last read beat's own range status is folded in directly.
            if (r_hs) begin
                if (last_beat) begin
                    err_q <= 1'b0;
                    if ((err_q || beat_oor) && (err_cnt != 16'hFFFF)) begin
                        err_cnt <= err_cnt + 16'd1;
                    end
                end else begin
                    err_q  <= err_q || beat_oor;
                    cnt_q  <= cnt_q - 8'd1;
                    addr_q <= addr_q + beat_step;
                end
            end
        end
    end

    assign ram_en = (w_hs && !beat_oor) || (state == RD_FETCH);

    cl_axi_slv_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (aclk),
        .en    (ram_en),
        .we    ((w_hs && !beat_oor) ? cl_axi_slv_bus.wstrb : '0),
        .addr  (addr_q[LINE_OFS +: LAW]),
        .wdata (cl_axi_slv_bus.wdata),
        .rdata (ram_rdata)
    );

    assign cl_axi_slv_bus.wready = (state == WR_DATA);
    assign cl_axi_slv_bus.bvalid = (state == WR_RESP);
    assign cl_axi_slv_bus.bid    = id_q;
    assign cl_axi_slv_bus.bresp  = ((state == WR_RESP) && err_q) ? RESP_SLVERR : RESP_OKAY;

    assign cl_axi_slv_bus.rvalid = (state == RD_DATA);
    assign cl_axi_slv_bus.rid    = id_q;
    assign cl_axi_slv_bus.rdata  = ((state == RD_DATA) && !beat_oor) ? ram_rdata : '0;
    assign cl_axi_slv_bus.rresp  = ((state == RD_DATA) && beat_oor) ? RESP_SLVERR : RESP_OKAY;
    assign cl_axi_slv_bus.rlast  = (state == RD_DATA) && last_beat;

    assign busy = (state != IDLE);

endmodule

// File: doc/cl_axi_slv_mem.md
Name: cl_axi_slv_mem

Overview:
- AXI4 responder (slave) on the 512-bit/64-bit-address axi_bus_t, backed by a byte-enabled on-chip line memory.
- It is the far end for the register-driven AXI master and for PCIS-side masters, used in simulation and as a scratchpad behind the interconnect.
- Services one transaction at a time (write or read burst) with ID echo, INCR addressing, and SLVERR on out-of-range beats.

Parameters:
- DEPTH, 1024, number of 64-byte lines; legal values are powers of two, 16..4096.
- LAW, $clog2(DEPTH), line index width (derived; do not override).

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous assert, active-low
- cl_axi_slv_bus  axi_bus_t.master  -  AXI bus. The block drives awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid; it samples all other signals.
- busy  out  1  high whenever the state is not IDLE
- err_cnt  out  16  count of transactions answered SLVERR, saturating at 16'hFFFF

Behaviour:
- Reset (async, aresetn=0): state=IDLE; awready, wready, bvalid, arready, rvalid, rlast, busy all 0; bid, rid, bresp, rresp = 0; rdata = 0; err_cnt = 0. Memory contents are not cleared. Assertion mid-burst aborts the transaction immediately with no response. Deassertion is synchronized externally.
- States: IDLE, WR_DATA, WR_RESP, RD_FETCH, RD_DATA.
- IDLE:
  - awready and arready are high only in IDLE. Accept at most one request per cycle.
  - If both awvalid and arvalid are high: grant the direction not granted last (prio flop, reset value = write first).
  - Capture id, addr, len, size into registers; beat counter = len.
  - On AW handshake go to WR_DATA. On AR handshake go to RD_FETCH.
- Beat addressing:
  - Beat address starts at axaddr and increments by (1<<axsize) after each beat. axburst is ignored; all bursts are treated as INCR.
  - line = beat_addr[6+LAW-1:6].
  - A beat is out-of-range if beat_addr[63:6] >= DEPTH.
- WR_DATA:
  - wready=1. On each W handshake: if the beat is in range, write the bytes with wstrb[i]=1 into the line; if out of range, drop the write and set the err flag.
  - On the final beat (count==0) go to WR_RESP. wlast is not used for sequencing. A mismatch between wlast and count==0 sets the err flag.
- WR_RESP:
  - bvalid=1, bid=captured id, bresp = err ? 2'b10 : 2'b00.
  - On bready go to IDLE, clear err, and increment err_cnt if err was set.
- RD_FETCH: one cycle; issue the synchronous RAM read for the current line, then go to RD_DATA.
- RD_DATA:
  - rvalid=1, rid=captured id. rdata = RAM output, or all zeros if the beat is out of range.
  - rresp = 2'b10 for an out-of-range beat, else 2'b00. rlast = (count==0).
  - rdata, rresp and rlast are held stable while rvalid && !rready.
  - On rready: if last, go to IDLE and update err_cnt as for writes; else decrement count, advance the address, and go to RD_FETCH.
  - Throughput is 1 beat per 2 cycles. First-data latency after the AR handshake is 2 cycles.
- A write followed by a read to the same line returns the new data, because the write completes in WR_DATA before any read is granted.
- Narrow (4-byte) accesses need no lane shifting in the slave: the master places data at byte lane addr[5:0] and the slave writes strobed bytes only.
- Write collisions in the RAM are impossible, since only one transaction is active at a time.

Decomposition:
- cl_axi_slv_pkg holds:
  - the state enum (3-bit);
  - localparams RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - LINE_BYTES = 64.
- Sub-module cl_axi_slv_ram: single-port, DEPTH x 512, 64 byte-write-enables, synchronous read with 1-cycle latency, and no reset on the array.

Test Plan:
- Single write, then read: AW addr 0x40, size 2, len 0, wstrb 0xF, wdata 0xDEADBEEF, then AR addr 0x40 -> bresp 0, bid echoed, rdata[31:0] = 0xDEADBEEF, rlast = 1.
- Narrow lane write: addr 0x3C, wdata 0x12345678<<480, wstrb 0xF<<60 -> a read of line 0 returns bytes 60..63 = 78 56 34 12 and all other bytes unchanged.
- Burst: AW addr 0, len 3, size 6 with 4 distinct lines, then AR len 3 with arid 0x5 -> 4 beats in order, rid = 0x5, rlast only on beat 3, 2-cycle spacing per beat.
- Out-of-range crossing (DEPTH=16): AR addr 0x3C0, len 1, size 6 -> beat 0 returns data with OKAY, beat 1 returns zeros with SLVERR, err_cnt = 1.
- Simultaneous awvalid and arvalid in IDLE twice in a row -> write granted first, read second. rready held low 5 cycles -> rdata stable throughout.
- Async reset asserted mid-read burst -> rvalid and busy fall to 0 with no clock edge; next AR after reset is serviced normally and memory data is retained.
